// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM pipeline latch plus the data-memory handshake.
// Runs single-access loads/stores and two-access indirect ops (LDI/STI).
// Ops with no memory access go straight to writeback.
// Optional build macro MEM_STALL_COUNT_EN enables a free-running count of stalled cycles.
// When it is undefined, mem_stall_cycles is tied to zero.

package lc3b_pkg;

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;

  typedef struct packed {
    logic [3:0] opcode;
    logic       mem_read;
    logic       mem_write;
    logic       load_cc;
    logic       load_regfile;
    logic       branch_stall;
  } lc3b_control_word;

endpackage

module mem_access_stage
  import lc3b_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_mem,
  input  logic                ex_valid,
  input  lc3b_control_word    ex_cw,
  input  logic                ex_indirect,
  input  logic [WIDTH-1:0]    ex_address,
  input  logic [WIDTH-1:0]    ex_result,
  input  logic [WIDTH-1:0]    ex_store_data,
  input  logic [WIDTH-1:0]    ex_npc,
  input  logic [REG_BITS-1:0] ex_dr,
  input  logic                dmem_resp,
  input  logic [WIDTH-1:0]    dmem_rdata,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [WIDTH-1:0]    dmem_address,
  output logic [WIDTH-1:0]    dmem_wdata,
  output logic                mem_stall,
  output logic                mem_br_stall,
  output logic                wb_valid,
  output logic [WIDTH-1:0]    wb_data,
  output logic [REG_BITS-1:0] wb_dr,
  output logic                wb_load_regfile,
  output logic                wb_load_cc,
  output logic [31:0]         mem_stall_cycles
);

  typedef enum logic [1:0] {IDLE, ACCESS, PTR, FINAL} state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  lc3b_control_word      cw_q, cw_d;
  logic [WIDTH-1:0]      address_q, address_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [WIDTH-1:0]      store_data_q, store_data_d;
  logic [WIDTH-1:0]      npc_q, npc_d;
  logic [REG_BITS-1:0]   dr_q, dr_d;
  logic [WIDTH-1:0]      ptr_q, ptr_d;
  logic [WIDTH-1:0]      mdata_q, mdata_d;
  logic                  wb_pend_q, wb_pend_d;

  logic                  capture;
  logic                  is_load;
  logic                  unused_npc;

  // The latch only opens while the stage is idle, so a busy stage always wins over load_mem.
  assign capture = load_mem & ~mem_stall;

  // NPC rides along with the op for downstream consumers but is not used in this stage.
  assign unused_npc = ^npc_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: the access kind is decided from execute's inputs on the capture edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (capture && ex_valid) begin
          if (ex_indirect)                              state_d = PTR;
          else if (ex_cw.mem_read || ex_cw.mem_write)   state_d = ACCESS;
        end
      end
      ACCESS:  if (dmem_resp) state_d = IDLE;
      PTR:     if (dmem_resp) state_d = FINAL;
      FINAL:   if (dmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory request outputs; they depend only on registered state, so they stay stable until the response.
  always_comb begin
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = '0;
    dmem_wdata   = '0;
    mem_stall    = 1'b0;
    unique case (state_q)
      ACCESS: begin
        mem_stall    = 1'b1;
        dmem_address = address_q;
        dmem_read    = cw_q.mem_read;
        dmem_write   = cw_q.mem_write & ~cw_q.mem_read;
        dmem_wdata   = (cw_q.mem_write & ~cw_q.mem_read) ? store_data_q : '0;
      end
      PTR: begin
        mem_stall    = 1'b1;
        dmem_address = address_q;
        dmem_read    = 1'b1;
      end
      FINAL: begin
        mem_stall    = 1'b1;
        dmem_address = ptr_q;
        dmem_write   = cw_q.mem_write;
        dmem_read    = ~cw_q.mem_write;
        dmem_wdata   = cw_q.mem_write ? store_data_q : '0;
      end
      default: ;
    endcase
  end

  // Datapath next values: the EX/MEM latch, the pointer and read-data captures, and the one-shot writeback flag.
  always_comb begin
    valid_d      = valid_q;
    cw_d         = cw_q;
    address_d    = address_q;
    result_d     = result_q;
    store_data_d = store_data_q;
    npc_d        = npc_q;
    dr_d         = dr_q;
    ptr_d        = ptr_q;
    mdata_d      = mdata_q;
    wb_pend_d    = 1'b0;
    if (capture) begin
      valid_d      = ex_valid;
      cw_d         = ex_cw;
      address_d    = ex_address;
      result_d     = ex_result;
      store_data_d = ex_store_data;
      npc_d        = ex_npc;
      dr_d         = ex_dr;
      wb_pend_d    = ex_valid & ~ex_indirect & ~ex_cw.mem_read & ~ex_cw.mem_write;
    end
    if (dmem_resp) begin
      unique case (state_q)
        ACCESS: begin
          mdata_d   = dmem_rdata;
          wb_pend_d = 1'b1;
        end
        PTR:   ptr_d = dmem_rdata;
        FINAL: begin
          mdata_d   = dmem_rdata;
          wb_pend_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset clears everything so all writeback outputs read zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      cw_q         <= '0;
      address_q    <= '0;
      result_q     <= '0;
      store_data_q <= '0;
      npc_q        <= '0;
      dr_q         <= '0;
      ptr_q        <= '0;
      mdata_q      <= '0;
      wb_pend_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      cw_q         <= cw_d;
      address_q    <= address_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
      npc_q        <= npc_d;
      dr_q         <= dr_d;
      ptr_q        <= ptr_d;
      mdata_q      <= mdata_d;
      wb_pend_q    <= wb_pend_d;
    end
  end

  // Writeback and branch-stall outputs.
  always_comb begin
    is_load         = (cw_q.opcode == OP_LDR) || (cw_q.opcode == OP_LDB) || (cw_q.opcode == OP_LDI);
    wb_valid        = wb_pend_q;
    wb_data         = is_load ? mdata_q : result_q;
    wb_dr           = dr_q;
    wb_load_regfile = wb_pend_q & cw_q.load_regfile;
    wb_load_cc      = wb_pend_q & cw_q.load_cc;
    mem_br_stall    = valid_q & cw_q.branch_stall;
  end

`ifdef MEM_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall-cycle counter next value; it wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign mem_stall_cycles = stall_cnt_q;
`else
  assign mem_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage.
// A reference model predicts every memory access and writeback result at issue time.
// The predictions go into queues. A memory responder and a writeback monitor pop and compare them.

module tb_mem_access_stage;
  import lc3b_pkg::*;

  localparam int WIDTH    = 16;
  localparam int REG_BITS = 3;

  typedef enum int {K_ALU, K_BR, K_LDR, K_LDB, K_STR, K_STB, K_LDI, K_STI} kind_e;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dr;
    logic        lrf;
    logic        lcc;
  } wb_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                load_mem;
  logic                ex_valid;
  lc3b_control_word    ex_cw;
  logic                ex_indirect;
  logic [WIDTH-1:0]    ex_address;
  logic [WIDTH-1:0]    ex_result;
  logic [WIDTH-1:0]    ex_store_data;
  logic [WIDTH-1:0]    ex_npc;
  logic [REG_BITS-1:0] ex_dr;
  logic                dmem_resp;
  logic [WIDTH-1:0]    dmem_rdata;
  logic                dmem_read;
  logic                dmem_write;
  logic [WIDTH-1:0]    dmem_address;
  logic [WIDTH-1:0]    dmem_wdata;
  logic                mem_stall;
  logic                mem_br_stall;
  logic                wb_valid;
  logic [WIDTH-1:0]    wb_data;
  logic [REG_BITS-1:0] wb_dr;
  logic                wb_load_regfile;
  logic                wb_load_cc;
  logic [31:0]         mem_stall_cycles;

  wb_t  exp_wb[$];
  acc_t exp_acc[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] dev_mem [logic [15:0]];

  int checks       = 0;
  int errors       = 0;
  int forced_lat   = 0;
  int stray_pulses = 0;
  int stall_seen   = 0;
  int read_seen    = 0;

  mem_access_stage #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_mem         (load_mem),
    .ex_valid         (ex_valid),
    .ex_cw            (ex_cw),
    .ex_indirect      (ex_indirect),
    .ex_address       (ex_address),
    .ex_result        (ex_result),
    .ex_store_data    (ex_store_data),
    .ex_npc           (ex_npc),
    .ex_dr            (ex_dr),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .mem_stall        (mem_stall),
    .mem_br_stall     (mem_br_stall),
    .wb_valid         (wb_valid),
    .wb_data          (wb_data),
    .wb_dr            (wb_dr),
    .wb_load_regfile  (wb_load_regfile),
    .wb_load_cc       (wb_load_cc),
    .mem_stall_cycles (mem_stall_cycles)
  );

  always #5 clk = ~clk;

  // Power-on memory image, used until an address is first written.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] dev_rd(input logic [15:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    ref_mem[a] = d;
    dev_mem[a] = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input int actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d, expected the event before the bound", name, actual);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic waitIdle(input string name);
    int g;
    g = 0;
    while (mem_stall && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) failNow(name, g);
  endtask

  // Issues one op from execute and pushes the model's predicted accesses and writeback.
  task automatic applyStimulus(input kind_e k, input bit v, input logic [15:0] addr,
                               input logic [15:0] result, input logic [15:0] sdata,
                               input logic [2:0] dr);
    lc3b_control_word cw;
    bit               ind;
    wb_t              w;
    logic [15:0]      p;
    cw  = '0;
    ind = 1'b0;
    case (k)
      K_ALU: begin cw.opcode = 4'b0001; cw.load_regfile = 1'b1; cw.load_cc = 1'b1; end
      K_BR:  begin cw.opcode = 4'b0000; cw.branch_stall = 1'b1; end
      K_LDR: begin cw.opcode = 4'b0110; cw.mem_read = 1'b1; cw.load_regfile = 1'b1; cw.load_cc = 1'b1; end
      K_LDB: begin cw.opcode = 4'b0010; cw.mem_read = 1'b1; cw.load_regfile = 1'b1; cw.load_cc = 1'b1; end
      K_STR: begin cw.opcode = 4'b0111; cw.mem_write = 1'b1; end
      K_STB: begin cw.opcode = 4'b0011; cw.mem_write = 1'b1; end
      K_LDI: begin cw.opcode = 4'b1010; cw.mem_read = 1'b1; cw.load_regfile = 1'b1; cw.load_cc = 1'b1; ind = 1'b1; end
      K_STI: begin cw.opcode = 4'b1011; cw.mem_write = 1'b1; ind = 1'b1; end
      default: ;
    endcase
    waitIdle("issue_timeout");
    load_mem      = 1'b1;
    ex_valid      = v;
    ex_cw         = cw;
    ex_indirect   = ind;
    ex_address    = addr;
    ex_result     = result;
    ex_store_data = sdata;
    ex_npc        = result + 16'd2;
    ex_dr         = dr;
    if (v) begin
      w.data = result;
      w.dr   = dr;
      w.lrf  = cw.load_regfile;
      w.lcc  = cw.load_cc;
      case (k)
        K_LDR, K_LDB: begin
          exp_acc.push_back('{wr: 1'b0, addr: addr, wdata: 16'h0});
          w.data = ref_rd(addr);
        end
        K_STR, K_STB: begin
          exp_acc.push_back('{wr: 1'b1, addr: addr, wdata: sdata});
          ref_mem[addr] = sdata;
        end
        K_LDI: begin
          exp_acc.push_back('{wr: 1'b0, addr: addr, wdata: 16'h0});
          p = ref_rd(addr);
          exp_acc.push_back('{wr: 1'b0, addr: p, wdata: 16'h0});
          w.data = ref_rd(p);
        end
        K_STI: begin
          exp_acc.push_back('{wr: 1'b0, addr: addr, wdata: 16'h0});
          p = ref_rd(addr);
          exp_acc.push_back('{wr: 1'b1, addr: p, wdata: sdata});
          ref_mem[p] = sdata;
        end
        default: ;
      endcase
      exp_wb.push_back(w);
    end
    @(posedge clk); #1;
    load_mem = 1'b0;
    ex_valid = 1'b0;
  endtask

  // Data memory model. It answers each request after a random or forced latency and checks it against the predicted accesses.
  initial begin
    int          cnt;
    int          lat;
    int          stray_done;
    logic [15:0] first_addr;
    acc_t        e;
    cnt        = 0;
    lat        = 1;
    stray_done = 0;
    first_addr = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_resp = 1'b0;
      if (stray_done < stray_pulses) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 16'hDEAD;
        stray_done++;
      end else if (reset_n === 1'b1 && (dmem_read === 1'b1 || dmem_write === 1'b1)) begin
        if (cnt == 0) begin
          lat        = (forced_lat > 0) ? forced_lat : int'($urandom_range(1, 4));
          first_addr = dmem_address;
        end
        cnt++;
        if (cnt >= lat) begin
          checkOutput("acc_rw_exclusive", {31'd0, dmem_read & dmem_write}, 32'd0);
          checkOutput("acc_addr_stable", {16'd0, dmem_address}, {16'd0, first_addr});
          if (exp_acc.size() == 0) begin
            failNow("acc_unexpected", int'(dmem_address));
          end else begin
            e = exp_acc.pop_front();
            checkOutput("acc_kind", {31'd0, dmem_write}, {31'd0, e.wr});
            checkOutput("acc_addr", {16'd0, dmem_address}, {16'd0, e.addr});
            if (e.wr) checkOutput("acc_wdata", {16'd0, dmem_wdata}, {16'd0, e.wdata});
          end
          if (dmem_write) begin
            dev_mem[dmem_address] = dmem_wdata;
            dmem_rdata = 16'($urandom);
          end else begin
            dmem_rdata = dev_rd(dmem_address);
          end
          dmem_resp = 1'b1;
          cnt       = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Writeback monitor: each wb_valid must match the oldest predicted result.
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && wb_valid === 1'b1) begin
        if (exp_wb.size() == 0) begin
          failNow("wb_unexpected", int'(wb_data));
        end else begin
          w = exp_wb.pop_front();
          checkOutput("wb_data", {16'd0, wb_data}, {16'd0, w.data});
          checkOutput("wb_dr", {29'd0, wb_dr}, {29'd0, w.dr});
          checkOutput("wb_load_regfile", {31'd0, wb_load_regfile}, {31'd0, w.lrf});
          checkOutput("wb_load_cc", {31'd0, wb_load_cc}, {31'd0, w.lcc});
        end
      end
    end
  end

  // Tallies stalled and reading cycles since the last reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        stall_seen = 0;
        read_seen  = 0;
      end else begin
        if (mem_stall === 1'b1) stall_seen++;
        if (dmem_read === 1'b1) read_seen++;
      end
    end
  end

  // Main sequence: reset, the directed scenarios, a randomized mix, then drain and summary.
  initial begin
    int          s0;
    int          r0;
    int          g;
    logic [31:0] c0;
    kind_e       k;
    bit          v;
    logic [15:0] a;

    reset_n       = 1'b0;
    load_mem      = 1'b0;
    ex_valid      = 1'b0;
    ex_cw         = '0;
    ex_indirect   = 1'b0;
    ex_address    = '0;
    ex_result     = '0;
    ex_store_data = '0;
    ex_npc        = '0;
    ex_dr         = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dmem_read", {31'd0, dmem_read}, 32'd0);
    checkOutput("rst_dmem_write", {31'd0, dmem_write}, 32'd0);
    checkOutput("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("rst_mem_br_stall", {31'd0, mem_br_stall}, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_data", {16'd0, wb_data}, 32'd0);
    checkOutput("rst_wb_dr", {29'd0, wb_dr}, 32'd0);
    checkOutput("rst_wb_lrf", {31'd0, wb_load_regfile}, 32'd0);
    checkOutput("rst_stall_cycles", mem_stall_cycles, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] ADD: one-cycle writeback, no stall");
    s0 = stall_seen;
    applyStimulus(K_ALU, 1'b1, 16'h0000, 16'h1234, 16'h0000, 3'd3);
    checkOutput("add_wb_latency", {31'd0, wb_valid}, 32'd1);
    @(posedge clk); #1;
    checkOutput("add_no_stall", stall_seen - s0, 32'd0);

    $display("[TB] LDR with three-cycle memory latency");
    preload(16'h0040, 16'hBEEF);
    forced_lat = 3;
    s0 = stall_seen;
    r0 = read_seen;
    applyStimulus(K_LDR, 1'b1, 16'h0040, 16'h5555, 16'h0000, 3'd5);
    waitIdle("ldr_timeout");
    checkOutput("ldr_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("ldr_stall_cycles", stall_seen - s0, 32'd3);
    checkOutput("ldr_read_cycles", read_seen - r0, 32'd3);
    forced_lat = 0;

    $display("[TB] STI through pointer");
    preload(16'h0100, 16'h2000);
    applyStimulus(K_STI, 1'b1, 16'h0100, 16'h1111, 16'h00AA, 3'd1);
    waitIdle("sti_timeout");
    @(posedge clk); #1;
    checkOutput("sti_mem_written", {16'd0, dev_rd(16'h2000)}, 32'h0000_00AA);

    $display("[TB] LDI through pointer, continuous stall");
    preload(16'h0200, 16'h3000);
    preload(16'h3000, 16'h7777);
    forced_lat = 2;
    s0 = stall_seen;
    applyStimulus(K_LDI, 1'b1, 16'h0200, 16'h2222, 16'h0000, 3'd6);
    waitIdle("ldi_timeout");
    checkOutput("ldi_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("ldi_stall_cycles", stall_seen - s0, 32'd4);
    forced_lat = 0;

    $display("[TB] branch_stall residency followed by back-to-back ADD");
    applyStimulus(K_BR, 1'b1, 16'h0000, 16'h0ABC, 16'h0000, 3'd0);
    checkOutput("br_stall_resident", {31'd0, mem_br_stall}, 32'd1);
    applyStimulus(K_ALU, 1'b1, 16'h0000, 16'h4321, 16'h0000, 3'd2);
    checkOutput("br_stall_gone", {31'd0, mem_br_stall}, 32'd0);
    checkOutput("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);

`ifdef MEM_STALL_COUNT_EN
    $display("[TB] five-cycle stall increments the counter by five");
    forced_lat = 5;
    c0 = mem_stall_cycles;
    applyStimulus(K_LDR, 1'b1, 16'h0041, 16'h0000, 16'h0000, 3'd4);
    waitIdle("cnt_timeout");
    checkOutput("stall_cnt_plus5", mem_stall_cycles - c0, 32'd5);
    forced_lat = 0;
`else
    c0 = 32'd0;
    checkOutput("stall_cnt_tied", mem_stall_cycles, c0);
`endif

    $display("[TB] reset during pointer fetch, then a stray response");
    forced_lat = 1000;
    applyStimulus(K_LDI, 1'b1, 16'h0300, 16'h0000, 16'h0000, 3'd7);
    checkOutput("ptr_read_active", {31'd0, dmem_read}, 32'd1);
    checkOutput("ptr_stall_active", {31'd0, mem_stall}, 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("rst_mid_read", {31'd0, dmem_read}, 32'd0);
    checkOutput("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    exp_wb.delete();
    exp_acc.delete();
    forced_lat = 0;
    stray_pulses++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stray_no_wb", {31'd0, wb_valid}, 32'd0);
      checkOutput("stray_no_stall", {31'd0, mem_stall}, 32'd0);
    end

    $display("[TB] randomized op mix");
    for (int i = 0; i < 150; i++) begin
      k = kind_e'($urandom_range(0, 7));
      v = ($urandom_range(0, 9) != 0);
      a = 16'h0040 + 16'($urandom_range(0, 15));
      applyStimulus(k, v, a, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    g = 0;
    while ((exp_wb.size() != 0 || mem_stall) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) failNow("drain_timeout", exp_wb.size());
    @(posedge clk); #1;
    checkOutput("acc_leftover", exp_acc.size(), 32'd0);
`ifdef MEM_STALL_COUNT_EN
    checkOutput("stall_cnt_total", mem_stall_cycles, stall_seen);
`else
    checkOutput("stall_cnt_zero_end", mem_stall_cycles, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
